// File: rtl/vga_video_monitor.sv
// vga_video_monitor
//   Sink-side checker for a VGA-style video stream (active-high syncs + RGB).
//   It measures line and frame timing against the nominal geometry. It declares
//   lock after LOCK_FRAMES consecutive good frames. It also produces a per-frame
//   pixel checksum, so the pattern generator can be self-tested.
//
//   Optional feature: define VIDEO_MON_CRC_EN to replace the additive checksum
//   with CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no xorout).
//   The CRC is fed 3*VIDEO_WIDTH bits per active pixel, MSB first, red first.
//   Timing and FSM behaviour are the same in both builds.
//
// Ports
//   i_clk, i_rst           pixel clock, synchronous active-high reset
//   i_hsync, i_vsync       high during active columns / active rows
//   i_red/green/blue_video pixel data, aligned with the syncs
//   o_locked               timing locked
//   o_frame_done           1-cycle pulse when a measured frame completes
//   o_frame_ok             result of the last measured frame
//   o_checksum             checksum of the last measured frame
//   o_err_count            timing errors since reset, saturating at 255
module vga_video_monitor #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic [VIDEO_WIDTH-1:0] i_red_video,
  input  logic [VIDEO_WIDTH-1:0] i_green_video,
  input  logic [VIDEO_WIDTH-1:0] i_blue_video,
  output logic                   o_locked,
  output logic                   o_frame_done,
  output logic                   o_frame_ok,
  output logic [15:0]            o_checksum,
  output logic [7:0]             o_err_count
);

  localparam int CW    = 11;
  localparam int PIX_W = 3 * VIDEO_WIDTH;

  localparam logic [CW-1:0] TOT_COLS  = CW'(TOTAL_COLS);
  localparam logic [CW-1:0] ACT_COLS  = CW'(ACTIVE_COLS);
  localparam logic [CW-1:0] TOT_ROWS  = CW'(TOTAL_ROWS);
  localparam logic [CW-1:0] ACT_ROWS  = CW'(ACTIVE_ROWS);
  localparam logic [CW-1:0] COL_LIMIT = CW'(2 * TOTAL_COLS);
  localparam logic [CW-1:0] ROW_LIMIT = CW'(2 * TOTAL_ROWS);
  localparam logic [4:0]    LOCK_N    = 5'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

`ifdef VIDEO_MON_CRC_EN
  localparam logic [15:0] SUM_INIT = 16'hFFFF;

  function automatic logic [15:0] sum_step(input logic [15:0] acc_in,
                                           input logic [PIX_W-1:0] pix_in);
    logic [15:0] c;
    c = acc_in;
    for (int i = PIX_W - 1; i >= 0; i--) begin
      if (c[15] ^ pix_in[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                   c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`else
  localparam logic [15:0] SUM_INIT = 16'h0000;

  function automatic logic [15:0] sum_step(input logic [15:0] acc_in,
                                           input logic [PIX_W-1:0] pix_in);
    return acc_in + 16'(pix_in);
  endfunction
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  state_t           state, state_next;
  logic             hsync_d, vsync_d;
  logic             h_rise, h_fall, v_rise;
  logic [CW-1:0]    col_cnt, act_cnt, row_cnt, act_rows;
  logic             line_valid, frame_err;
  logic [3:0]       good_cnt;
  logic [15:0]      acc;
  logic [PIX_W-1:0] pix;
  logic             line_bad, frame_bad, timeout;
  logic             frame_end, err_inc;

  assign h_rise = i_hsync & ~hsync_d;
  assign h_fall = ~i_hsync & hsync_d;
  assign v_rise = i_vsync & ~vsync_d;
  assign pix    = {i_red_video, i_green_video, i_blue_video};

  // The line measurements are meaningless until one full h_rise has been seen
  // since reset, so line_valid gates both the period check and the width check.
  assign line_bad  = line_valid &
                     ((h_rise & ((col_cnt + CW'(1)) != TOT_COLS)) |
                      (h_fall & (act_cnt != ACT_COLS)));
  // Evaluated in the v_rise cycle. The line closing here still belongs to the
  // frame that is ending.
  assign frame_bad = frame_err | line_bad |
                     (row_cnt != TOT_ROWS) | (act_rows != ACT_ROWS);
  assign timeout   = (state != SEARCH) &
                     ((col_cnt >= COL_LIMIT) | (row_cnt >= ROW_LIMIT));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= SEARCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    err_inc    = 1'b0;
    case (state)
      SEARCH: begin
        if (v_rise) state_next = MEASURE;
      end
      MEASURE: begin
        if (timeout) begin
          state_next = SEARCH;
          err_inc    = 1'b1;
        end else if (v_rise) begin
          frame_end = 1'b1;
          if (!frame_bad && (({1'b0, good_cnt} + 5'd1) >= LOCK_N))
            state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_next = SEARCH;
          err_inc    = 1'b1;
        end else if (v_rise) begin
          frame_end = 1'b1;
          if (frame_bad) begin
            state_next = MEASURE;
            err_inc    = 1'b1;
          end
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // The sync delays restart high, so syncs that are already high when reset
      // is released do not look like a fresh edge. A real rise is required.
      hsync_d      <= 1'b1;
      vsync_d      <= 1'b1;
      col_cnt      <= '0;
      act_cnt      <= '0;
      row_cnt      <= '0;
      act_rows     <= '0;
      line_valid   <= 1'b0;
      frame_err    <= 1'b0;
      good_cnt     <= '0;
      acc          <= '0;
      o_locked     <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_checksum   <= '0;
      o_err_count  <= '0;
    end else begin
      hsync_d <= i_hsync;
      vsync_d <= i_vsync;

      // col_cnt + 1 at the next h_rise is the line period.
      if (h_rise) col_cnt <= '0;
      else        col_cnt <= sat_inc_cnt(col_cnt);

      if (h_rise)       act_cnt <= CW'(1);
      else if (i_hsync) act_cnt <= sat_inc_cnt(act_cnt);

      if (h_rise) line_valid <= 1'b1;

      // The v_rise cycle is also row 0's h_rise, so both row counts restart at 1.
      if (v_rise) begin
        row_cnt  <= CW'(1);
        act_rows <= CW'(1);
      end else if (h_rise) begin
        row_cnt <= sat_inc_cnt(row_cnt);
        if (i_vsync) act_rows <= sat_inc_cnt(act_rows);
      end

      if (v_rise)        frame_err <= 1'b0;
      else if (line_bad) frame_err <= 1'b1;

      // Pixel (0,0) arrives in the v_rise cycle and seeds the next frame.
      if (v_rise)                 acc <= sum_step(SUM_INIT, pix);
      else if (i_hsync & i_vsync) acc <= sum_step(acc, pix);

      if (state_next == SEARCH) good_cnt <= '0;
      else if (frame_end)       good_cnt <= frame_bad ? 4'd0
                                          : ((good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1);

      o_frame_done <= frame_end;
      if (frame_end) begin
        o_frame_ok <= ~frame_bad;
        o_checksum <= acc;
      end
      o_locked <= (state_next == LOCKED);
      if (err_inc) o_err_count <= sat_inc8(o_err_count);
    end
  end

endmodule

// File: tb/tb_vga_video_monitor.sv
// tb_vga_video_monitor
//   Directed bench for vga_video_monitor on a reduced 40x12 geometry
//   (32 active columns, 8 active rows) so that many frames run quickly.
//   Each send_frame call starts with the v_rise pixel. The monitor outputs
//   seen one cycle later report the previous frame.
module tb_vga_video_monitor;

  localparam int VW = 3;
  localparam int TC = 40;
  localparam int TR = 12;
  localparam int AC = 32;
  localparam int AR = 8;

  localparam int M_RED   = 0;
  localparam int M_GREEN = 1;
  localparam int M_BLUE  = 2;
  localparam int M_CHK   = 3;
  localparam int M_CHKF  = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_hsync;
  logic          i_vsync;
  logic [VW-1:0] i_red_video;
  logic [VW-1:0] i_green_video;
  logic [VW-1:0] i_blue_video;
  logic          o_locked;
  logic          o_frame_done;
  logic          o_frame_ok;
  logic [15:0]   o_checksum;
  logic [7:0]    o_err_count;

  int n_checks    = 0;
  int n_fail      = 0;
  int done_pulses = 0;

  logic        cap_done, cap_ok, cap_locked;
  logic [15:0] cap_sum;
  logic [7:0]  cap_err;

  vga_video_monitor #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .LOCK_FRAMES(2)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red_video(i_red_video), .i_green_video(i_green_video),
    .i_blue_video(i_blue_video), .o_locked(o_locked),
    .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok),
    .o_checksum(o_checksum), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_frame_done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [8:0] pix(input int mode, input int row, input int col);
    logic w;
    case (mode)
      M_RED:   return 9'h1C0;
      M_GREEN: return 9'h038;
      M_BLUE:  return 9'h007;
      default: begin
        w = ((row + col) % 2) == 1;
        if (mode == M_CHKF && row == 2 && col == 5) w = ~w;
        return w ? 9'h1FF : 9'h000;
      end
    endcase
  endfunction

`ifdef VIDEO_MON_CRC_EN
  function automatic logic [15:0] crc_frame(input int mode);
    logic [15:0] c;
    logic [8:0]  p;
    c = 16'hFFFF;
    for (int row = 0; row < AR; row++)
      for (int col = 0; col < AC; col++) begin
        p = pix(mode, row, col);
        for (int i = 8; i >= 0; i--)
          c = (c[15] ^ p[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    return c;
  endfunction
`endif

  // 256 active pixels per frame: red 448*256, green 56*256 and blue 7*256,
  // each mod 2^16. The checkerboard has 128 white pixels of 511. The flipped
  // variant has one fewer.
  function automatic logic [15:0] exp_sum(input int mode);
`ifdef VIDEO_MON_CRC_EN
    return crc_frame(mode);
`else
    case (mode)
      M_RED:   return 16'hC000;
      M_GREEN: return 16'h3800;
      M_BLUE:  return 16'h0700;
      M_CHK:   return 16'hFF80;
      default: return 16'hFD81;
    endcase
`endif
  endfunction

  // bad_row: that row has hsync high one clock short. rst_row: 1-cycle reset at col 5.
  task automatic send_frame(input int mode, input int bad_row, input int rst_row);
    logic [8:0] p;
    for (int row = 0; row < TR; row++)
      for (int col = 0; col < TC; col++) begin
        i_hsync = (col < ((row == bad_row) ? AC - 1 : AC));
        i_vsync = (row < AR);
        p = (i_hsync && i_vsync) ? pix(mode, row, col) : 9'h000;
        {i_red_video, i_green_video, i_blue_video} = p;
        i_rst = (row == rst_row && col == 5);
        tick;
        if (row == 0 && col == 0) begin
          cap_done   = o_frame_done;
          cap_ok     = o_frame_ok;
          cap_locked = o_locked;
          cap_sum    = o_checksum;
          cap_err    = o_err_count;
        end
        if (i_rst) begin
          check("midrst_locked", o_locked, 0);
          check("midrst_done", o_frame_done, 0);
          check("midrst_ok", o_frame_ok, 0);
          check("midrst_sum", o_checksum, 0);
          check("midrst_err", o_err_count, 0);
        end
      end
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_hsync = 1'b0;
    i_vsync = 1'b0;
    {i_red_video, i_green_video, i_blue_video} = '0;
    repeat (3) tick;
    check("rst_locked", o_locked, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_ok", o_frame_ok, 0);
    check("rst_sum", o_checksum, 0);
    check("rst_err", o_err_count, 0);
    i_rst = 1'b0;
    repeat (5) tick;

    send_frame(M_RED, -1, -1);
    check("f1_done", cap_done, 0);
    check("f1_locked", cap_locked, 0);
    send_frame(M_RED, -1, -1);
    check("f2_done", cap_done, 1);
    check("f2_ok", cap_ok, 1);
    check("f2_sum", cap_sum, exp_sum(M_RED));
    check("f2_locked", cap_locked, 0);
    send_frame(M_BLUE, -1, -1);
    check("f3_done", cap_done, 1);
    check("f3_sum", cap_sum, exp_sum(M_RED));
    check("f3_locked", cap_locked, 1);
    send_frame(M_GREEN, -1, -1);
    check("blue_sum", cap_sum, exp_sum(M_BLUE));
    check("blue_locked", cap_locked, 1);
    send_frame(M_RED, 4, -1);
    check("green_sum", cap_sum, exp_sum(M_GREEN));
    check("green_locked", cap_locked, 1);
    check("pulses_a", done_pulses, 4);

    send_frame(M_RED, -1, -1);
    check("bad_done", cap_done, 1);
    check("bad_ok", cap_ok, 0);
    check("bad_locked", cap_locked, 0);
    check("bad_err", cap_err, 1);
    send_frame(M_RED, -1, -1);
    check("relock1_ok", cap_ok, 1);
    check("relock1_locked", cap_locked, 0);
    send_frame(M_RED, -1, -1);
    check("relock2_locked", cap_locked, 1);
    check("relock2_err", cap_err, 1);

    i_hsync = 1'b0;
    i_vsync = 1'b0;
    {i_red_video, i_green_video, i_blue_video} = '0;
    repeat (30) tick;
    check("to_before_locked", o_locked, 1);
    repeat (70) tick;
    check("to_locked", o_locked, 0);
    check("to_err", o_err_count, 2);
    check("to_pulses", done_pulses, 7);

    send_frame(M_RED, -1, -1);
    check("to_f1_done", cap_done, 0);
    send_frame(M_RED, -1, -1);
    check("to_f2_done", cap_done, 1);
    check("to_f2_ok", cap_ok, 1);
    check("to_f2_locked", cap_locked, 0);

    send_frame(M_RED, -1, 3);
    check("rst_f_pre_done", cap_done, 1);
    send_frame(M_CHK, -1, -1);
    check("rst_f1_done", cap_done, 0);
    check("pulses_b", done_pulses, 9);
    send_frame(M_CHKF, -1, -1);
    check("rst_f2_done", cap_done, 1);
    check("chk_sum", cap_sum, exp_sum(M_CHK));
    check("chk_ok", cap_ok, 1);
    send_frame(M_CHK, -1, -1);
    check("chkf_sum", cap_sum, exp_sum(M_CHKF));
    check("chkf_locked", cap_locked, 1);
    send_frame(M_RED, -1, -1);
    check("chk2_sum", cap_sum, exp_sum(M_CHK));
    check("chk2_locked", cap_locked, 1);
    check("end_err", cap_err, 0);
    check("pulses_c", done_pulses, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
